// File: rtl/axi4_addr_router.sv
// 1-master to NSLV-slave AXI4 address router with base/mask decode and an
// internal DECERR target; read and write paths each carry one burst at a time.
module axi4_addr_router #(
  parameter int unsigned NSLV   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {32'h8000_0000, 32'h1000_0000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {32'hF000_0000, 32'hFFFF_FFF0}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_awvalid,
  output logic                       m_awready,
  input  logic [ADDR_W-1:0]          m_awaddr,
  input  logic [ID_W-1:0]            m_awid,
  input  logic [7:0]                 m_awlen,
  input  logic [2:0]                 m_awsize,
  input  logic [1:0]                 m_awburst,
  input  logic                       m_wvalid,
  output logic                       m_wready,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  input  logic                       m_wlast,
  output logic                       m_bvalid,
  input  logic                       m_bready,
  output logic [1:0]                 m_bresp,
  output logic [ID_W-1:0]            m_bid,
  input  logic                       m_arvalid,
  output logic                       m_arready,
  input  logic [ADDR_W-1:0]          m_araddr,
  input  logic [ID_W-1:0]            m_arid,
  input  logic [7:0]                 m_arlen,
  input  logic [2:0]                 m_arsize,
  input  logic [1:0]                 m_arburst,
  output logic                       m_rvalid,
  input  logic                       m_rready,
  output logic [DATA_W-1:0]          m_rdata,
  output logic [1:0]                 m_rresp,
  output logic                       m_rlast,
  output logic [ID_W-1:0]            m_rid,
  output logic [NSLV-1:0]            s_awvalid,
  input  logic [NSLV-1:0]            s_awready,
  output logic [NSLV*ADDR_W-1:0]     s_awaddr,
  output logic [NSLV*ID_W-1:0]       s_awid,
  output logic [NSLV*8-1:0]          s_awlen,
  output logic [NSLV*3-1:0]          s_awsize,
  output logic [NSLV*2-1:0]          s_awburst,
  output logic [NSLV-1:0]            s_wvalid,
  input  logic [NSLV-1:0]            s_wready,
  output logic [NSLV*DATA_W-1:0]     s_wdata,
  output logic [NSLV*(DATA_W/8)-1:0] s_wstrb,
  output logic [NSLV-1:0]            s_wlast,
  input  logic [NSLV-1:0]            s_bvalid,
  output logic [NSLV-1:0]            s_bready,
  input  logic [NSLV*2-1:0]          s_bresp,
  input  logic [NSLV*ID_W-1:0]       s_bid,
  output logic [NSLV-1:0]            s_arvalid,
  input  logic [NSLV-1:0]            s_arready,
  output logic [NSLV*ADDR_W-1:0]     s_araddr,
  output logic [NSLV*ID_W-1:0]       s_arid,
  output logic [NSLV*8-1:0]          s_arlen,
  output logic [NSLV*3-1:0]          s_arsize,
  output logic [NSLV*2-1:0]          s_arburst,
  input  logic [NSLV-1:0]            s_rvalid,
  output logic [NSLV-1:0]            s_rready,
  input  logic [NSLV*DATA_W-1:0]     s_rdata,
  input  logic [NSLV*2-1:0]          s_rresp,
  input  logic [NSLV-1:0]            s_rlast,
  input  logic [NSLV*ID_W-1:0]       s_rid
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R}      rstate_t;

  wstate_t         w_state, w_next;
  rstate_t         r_state, r_next;
  logic [NSLV-1:0] sel_w, sel_r;
  logic            err_w, err_r;
  logic [ID_W-1:0] awid_q, arid_q;
  logic [7:0]      arlen_q, beat_q;

  // Returns {err, one-hot select}; the lowest matching index wins
  function automatic logic [NSLV:0] decode(input logic [ADDR_W-1:0] addr);
    logic [NSLV:0] r;
    logic          found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!found && ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    r[NSLV] = !found;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      sel_w   <= '0;
      sel_r   <= '0;
      err_w   <= 1'b0;
      err_r   <= 1'b0;
      awid_q  <= '0;
      arid_q  <= '0;
      arlen_q <= '0;
      beat_q  <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (w_state == W_IDLE && m_awvalid) begin
        {err_w, sel_w} <= decode(m_awaddr);
        awid_q         <= m_awid;
      end
      if (r_state == R_IDLE && m_arvalid) begin
        {err_r, sel_r} <= decode(m_araddr);
        arid_q         <= m_arid;
        arlen_q        <= m_arlen;
        beat_q         <= '0;
      end else if (r_state == R_R && m_rvalid && m_rready) begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  // Write path: next state and channel routing
  always_comb begin
    w_next    = w_state;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    m_bid     = '0;
    s_awvalid = '0;
    s_awaddr  = '0;
    s_awid    = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    s_wvalid  = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = '0;
    s_bready  = '0;
    case (w_state)
      W_IDLE: if (m_awvalid) w_next = W_AW;
      W_AW: begin
        for (int unsigned i = 0; i < NSLV; i++) begin
          s_awaddr[i*ADDR_W +: ADDR_W] = m_awaddr;
          s_awid[i*ID_W +: ID_W]       = m_awid;
          s_awlen[i*8 +: 8]            = m_awlen;
          s_awsize[i*3 +: 3]           = m_awsize;
          s_awburst[i*2 +: 2]          = m_awburst;
        end
        s_awvalid = err_w ? '0 : (sel_w & {NSLV{m_awvalid}});
        m_awready = err_w | (|(s_awready & sel_w));
        if (m_awvalid && m_awready) w_next = W_W;
      end
      W_W: begin
        for (int unsigned i = 0; i < NSLV; i++) begin
          s_wdata[i*DATA_W +: DATA_W] = m_wdata;
          s_wstrb[i*STRB_W +: STRB_W] = m_wstrb;
        end
        s_wlast  = sel_w & {NSLV{m_wlast}};
        s_wvalid = err_w ? '0 : (sel_w & {NSLV{m_wvalid}});
        m_wready = err_w | (|(s_wready & sel_w));
        if (m_wvalid && m_wready && m_wlast) w_next = W_B;
      end
      W_B: begin
        s_bready = err_w ? '0 : (sel_w & {NSLV{m_bready}});
        if (err_w) begin
          m_bvalid = 1'b1;
          m_bresp  = 2'b11;
          m_bid    = awid_q;
        end else begin
          for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_w[i]) begin
              m_bvalid = s_bvalid[i];
              m_bresp  = s_bresp[i*2 +: 2];
              m_bid    = s_bid[i*ID_W +: ID_W];
            end
          end
        end
        if (m_bvalid && m_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read path: next state and channel routing; ERR target generates beats locally
  always_comb begin
    r_next    = r_state;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    m_rlast   = 1'b0;
    m_rid     = '0;
    s_arvalid = '0;
    s_araddr  = '0;
    s_arid    = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_rready  = '0;
    case (r_state)
      R_IDLE: if (m_arvalid) r_next = R_AR;
      R_AR: begin
        for (int unsigned i = 0; i < NSLV; i++) begin
          s_araddr[i*ADDR_W +: ADDR_W] = m_araddr;
          s_arid[i*ID_W +: ID_W]       = m_arid;
          s_arlen[i*8 +: 8]            = m_arlen;
          s_arsize[i*3 +: 3]           = m_arsize;
          s_arburst[i*2 +: 2]          = m_arburst;
        end
        s_arvalid = err_r ? '0 : (sel_r & {NSLV{m_arvalid}});
        m_arready = err_r | (|(s_arready & sel_r));
        if (m_arvalid && m_arready) r_next = R_R;
      end
      R_R: begin
        s_rready = err_r ? '0 : (sel_r & {NSLV{m_rready}});
        if (err_r) begin
          m_rvalid = 1'b1;
          m_rresp  = 2'b11;
          m_rid    = arid_q;
          m_rlast  = (beat_q == arlen_q);
        end else begin
          for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_r[i]) begin
              m_rvalid = s_rvalid[i];
              m_rdata  = s_rdata[i*DATA_W +: DATA_W];
              m_rresp  = s_rresp[i*2 +: 2];
              m_rlast  = s_rlast[i];
              m_rid    = s_rid[i*ID_W +: ID_W];
            end
          end
        end
        if (m_rvalid && m_rready && m_rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule
